// File: rtl/regfile_bank.sv
// regfile_bank
//   Multi-read-port register file: the NPC general-purpose registers.
//   NR_RPORT combinational read ports, one write port. Each entry has a
//   busy bit that is set when an instruction is issued with this entry as
//   its destination, and cleared when that entry is written back. The
//   decode stage uses the busy bits to detect RAW hazards.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active low
//   clr    in   synchronous clear of all entries and all busy bits
//   wen    in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   packed read addresses; port p is bits [ADDR_W*p +: ADDR_W]
//   rdata  out  packed read data; port p is bits [WIDTH*p +: WIDTH]
//   rbusy  out  busy bit of the entry that each read port addresses
//   bset   in   mark entry baddr busy
//   baddr  in   scoreboard set address
module regfile_bank #(
  parameter int               WIDTH     = 32,
  parameter int               ADDR_W    = 5,
  parameter int               NR_RPORT  = 2,
  parameter int               ZERO_REG  = 1,
  parameter int               BYPASS    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wen,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [NR_RPORT*ADDR_W-1:0] raddr,
  output logic [NR_RPORT*WIDTH-1:0]  rdata,
  output logic [NR_RPORT-1:0]        rbusy,
  input  logic                       bset,
  input  logic [ADDR_W-1:0]          baddr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  // Entry 0 is read-only when it is configured as the hardwired zero.
  function automatic logic addr_writable(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == ZERO_ADDR));
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic wr_ok_s;
  logic set_ok_s;

  assign wr_ok_s  = wen  && addr_writable(waddr);
  assign set_ok_s = bset && addr_writable(baddr);

  // Next state per entry: clear beats everything; an issue (set) to the
  // same entry as a retiring write leaves it busy, since the new producer
  // is still in flight.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i]  = clr ? RESET_VAL
                : (wr_ok_s && (waddr == ADDR_W'(i))) ? wdata
                : mem_q[i];
      busy_d[i] = clr ? 1'b0
                : (set_ok_s && (baddr == ADDR_W'(i))) ? 1'b1
                : (wr_ok_s  && (waddr == ADDR_W'(i))) ? 1'b0
                : busy_q[i];
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
      busy_q <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Combinational read ports. Forwarding is suppressed while in reset so
  // the ports show only reset state, and under clr because the entry is
  // about to be cleared rather than written.
  for (genvar p = 0; p < NR_RPORT; p++) begin : g_rport
    logic [ADDR_W-1:0] ra_s;
    logic              byp_s;
    logic              zero_s;

    assign ra_s   = raddr[p*ADDR_W +: ADDR_W];
    assign byp_s  = (BYPASS != 0) && rst && !clr && wr_ok_s && (waddr == ra_s);
    assign zero_s = (ZERO_REG != 0) && (ra_s == ZERO_ADDR);

    assign rdata[p*WIDTH +: WIDTH] = zero_s ? {WIDTH{1'b0}}
                                   : byp_s  ? wdata
                                   : mem_q[ra_s];
    assign rbusy[p] = zero_s ? 1'b0
                    : byp_s  ? 1'b0
                    : busy_q[ra_s];
  end

endmodule

// File: tb/tb_regfile_bank.sv
module tb_regfile_bank;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic        bset;
  logic [4:0]  baddr;

  logic [63:0] rdata_b;
  logic [1:0]  rbusy_b;
  logic [63:0] rdata_n;
  logic [1:0]  rbusy_n;

  // Default configuration: zero register and bypass enabled.
  regfile_bank dut (
    .clk(clk), .rst(rst), .clr(clr), .wen(wen), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .bset(bset), .baddr(baddr)
  );

  // Same stimulus, no bypass.
  regfile_bank #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .clr(clr), .wen(wen), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .bset(bset), .baddr(baddr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  // sel: 0/1 bypass rdata port0/1, 2 bypass rbusy, 3/4 no-bypass rdata, 5 no-bypass rbusy
  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return rdata_b[31:0];
      1:       return rdata_b[63:32];
      2:       return {30'd0, rbusy_b};
      3:       return rdata_n[31:0];
      4:       return rdata_n[63:32];
      5:       return {30'd0, rbusy_n};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = observe(e.sel);
      vectors++;
      assert (obs === e.val)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b0;
    clr   = 1'b0;
    wen   = 1'b0;
    waddr = 5'd0;
    wdata = 32'h0000_0000;
    raddr = {5'd6, 5'd5};
    bset  = 1'b0;
    baddr = 5'd0;

    #2;
    expect_val("reset_rdata0", 0, 32'h0000_0000);
    expect_val("reset_rbusy",  2, 32'h0000_0000);
    drain();

    at_neg(); at_neg();
    rst = 1'b1;

    // Pre-load entries 5 and 6, mark 6 busy.
    at_neg(); wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    at_neg(); waddr = 5'd6;
    at_neg(); wen = 1'b0; bset = 1'b1; baddr = 5'd6;
    at_neg(); bset = 1'b0;
    #1;
    expect_val("preload_rd0", 0, 32'hDEAD_BEEF);
    expect_val("preload_rd1", 1, 32'hDEAD_BEEF);
    expect_val("preload_busy", 2, 32'h0000_0002);
    drain();

    // Mid-cycle reset with a write pending: reads drop at once.
    wen = 1'b1; waddr = 5'd5; wdata = 32'h1111_1111;
    #2;
    rst = 1'b0;
    #1;
    expect_val("async_rst_rd0", 0, 32'h0000_0000);
    expect_val("async_rst_rd1", 1, 32'h0000_0000);
    expect_val("async_rst_busy", 2, 32'h0000_0000);
    expect_val("async_rst_nb_rd0", 3, 32'h0000_0000);
    drain();
    at_neg(); rst = 1'b1; wen = 1'b0;
    after_pos();
    expect_val("post_rst_rd0", 0, 32'h0000_0000);
    expect_val("post_rst_busy", 2, 32'h0000_0000);
    drain();

    // Basic write, both ports on the same entry.
    at_neg(); wen = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; raddr = {5'd5, 5'd5};
    #1;
    expect_val("wr_bypass_rd0", 0, 32'h1234_5678);
    expect_val("wr_nb_old_rd0", 3, 32'h0000_0000);
    drain();
    at_neg(); wen = 1'b0;
    #1;
    expect_val("wr_rd0", 0, 32'h1234_5678);
    expect_val("wr_rd1", 1, 32'h1234_5678);
    expect_val("wr_nb_rd0", 3, 32'h1234_5678);
    expect_val("wr_nb_rd1", 4, 32'h1234_5678);
    drain();

    // Bypass vs no bypass on entry 7.
    at_neg(); wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; raddr = {5'd5, 5'd7};
    #1;
    expect_val("byp_rd0", 0, 32'hA5A5_A5A5);
    expect_val("nobyp_old_rd0", 3, 32'h0000_0000);
    drain();
    after_pos();
    expect_val("nobyp_new_rd0", 3, 32'hA5A5_A5A5);
    drain();
    at_neg(); wen = 1'b0;

    // Zero register: write and bset to address 0 are dropped.
    at_neg(); wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    bset = 1'b1; baddr = 5'd0; raddr = {5'd0, 5'd0};
    #1;
    expect_val("zero_pre_rd0", 0, 32'h0000_0000);
    expect_val("zero_pre_busy", 2, 32'h0000_0000);
    drain();
    after_pos();
    expect_val("zero_post_rd0", 0, 32'h0000_0000);
    expect_val("zero_post_nb_rd1", 4, 32'h0000_0000);
    drain();
    at_neg(); wen = 1'b0; bset = 1'b0;
    #1;
    expect_val("zero_idle_rd0", 0, 32'h0000_0000);
    expect_val("zero_idle_nb_busy", 5, 32'h0000_0000);
    drain();

    // Scoreboard on entry 3 (read port 1).
    at_neg(); bset = 1'b1; baddr = 5'd3; raddr = {5'd3, 5'd5};
    at_neg(); bset = 1'b0;
    #1;
    expect_val("sb_set_busy", 2, 32'h0000_0002);
    drain();
    at_neg(); wen = 1'b1; waddr = 5'd3; wdata = 32'hCAFE_0003;
    #1;
    expect_val("sb_wb_byp_busy", 2, 32'h0000_0000);
    expect_val("sb_wb_nb_old_busy", 5, 32'h0000_0002);
    drain();
    after_pos();
    expect_val("sb_wb_nb_busy", 5, 32'h0000_0000);
    expect_val("sb_wb_nb_rd1", 4, 32'hCAFE_0003);
    drain();
    at_neg(); wen = 1'b1; bset = 1'b1; waddr = 5'd3; baddr = 5'd3; wdata = 32'h0BAD_F00D;
    at_neg(); wen = 1'b0; bset = 1'b0;
    #1;
    expect_val("sb_both_busy", 2, 32'h0000_0002);
    expect_val("sb_both_rd1", 1, 32'h0BAD_F00D);
    expect_val("sb_both_nb_busy", 5, 32'h0000_0002);
    drain();
    at_neg(); wen = 1'b1; waddr = 5'd3; wdata = 32'h0000_0001; bset = 1'b1; baddr = 5'd4;
    at_neg(); wen = 1'b0; bset = 1'b0; raddr = {5'd3, 5'd4};
    #1;
    expect_val("sb_diff_busy", 2, 32'h0000_0001);
    expect_val("sb_diff_rd0", 0, 32'h0000_0000);
    expect_val("sb_diff_rd1", 1, 32'h0000_0001);
    drain();

    // Clear overrides write and set.
    at_neg(); wen = 1'b1; waddr = 5'd9; wdata = 32'h0000_0077;
    at_neg(); wen = 1'b0; raddr = {5'd4, 5'd9};
    #1;
    expect_val("clr_pre_rd0", 0, 32'h0000_0077);
    expect_val("clr_pre_busy", 2, 32'h0000_0002);
    drain();
    at_neg(); clr = 1'b1; wen = 1'b1; waddr = 5'd9; wdata = 32'h0000_0005;
    bset = 1'b1; baddr = 5'd10;
    #1;
    expect_val("clr_no_byp_rd0", 0, 32'h0000_0077);
    drain();
    at_neg(); clr = 1'b0; wen = 1'b0; bset = 1'b0;
    #1;
    expect_val("clr_rd0", 0, 32'h0000_0000);
    expect_val("clr_busy", 2, 32'h0000_0000);
    expect_val("clr_nb_rd0", 3, 32'h0000_0000);
    drain();
    raddr = {5'd10, 5'd3};
    #1;
    expect_val("clr_e3_rd0", 0, 32'h0000_0000);
    expect_val("clr_e10_busy", 2, 32'h0000_0000);
    expect_val("clr_nb_e3", 3, 32'h0000_0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- Parametrised multi-read-port register file with asynchronous active-low reset; the successor of the single-register flip-flop template.
- Serves as the NPC general-purpose register file: NR_RPORT combinational read ports and one write port.
- Optional hardwired-zero entry 0 and optional write-to-read bypass.
- Per-entry busy scoreboard set at issue and cleared at writeback, so the decode stage can detect RAW hazards.

Parameters:
WIDTH, 32, data width of each entry
ADDR_W, 5, address width; depth = 2**ADDR_W entries
NR_RPORT, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as 0, ignores writes, is never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
RESET_VAL, 0, value loaded into every entry on reset and on clr

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
clr  input  1  synchronous clear of all entries and all busy bits
wen  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  WIDTH  write data
raddr  input  NR_RPORT*ADDR_W  read addresses; port p occupies bits [ADDR_W*(p+1)-1 : ADDR_W*p]
rdata  output  NR_RPORT*WIDTH  read data, same packing as raddr
rbusy  output  NR_RPORT  busy bit of the entry addressed by each read port
bset  input  1  mark entry baddr busy (instruction issued with destination baddr)
baddr  input  ADDR_W  scoreboard set address

Behaviour:
- Reset: rst low asynchronously forces every entry to RESET_VAL and every busy bit to 0, independent of clk.
  - While rst is low, rdata shows RESET_VAL on every port (0 for entry 0 when ZERO_REG=1) and rbusy = 0.
  - On rst deassertion, the first rising edge with rst high performs normal updates.
- Clear: clr high at a rising edge loads RESET_VAL into all entries and clears all busy bits.
  - clr overrides wen and bset in the same cycle.
- Write: wen high at a rising edge sets entry[waddr] <= wdata and clears busy[waddr].
  - Write latency is 1 cycle; the value is visible on an unbypassed read the following cycle.
- Reads are combinational: rdata[p] = entry[raddr[p]], with zero added latency.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - bset to address 0 is dropped.
  - Read of address 0 returns 0 regardless of RESET_VAL; rbusy for address 0 is 0.
- BYPASS=1: when wen=1, clr=0, waddr==raddr[p] and the address is not a dropped zero-register write, rdata[p] = wdata in the same cycle, and rbusy[p] = 0.
- BYPASS=0: a read of an address being written in the same cycle returns the old value and the old busy bit.
- Scoreboard:
  - bset high at an edge (clr=0) sets busy[baddr] <= 1.
  - If bset and wen target the same address in the same cycle, set wins and busy ends at 1; data is still written. This models a new producer issued while the old one retires.
  - If bset and wen target different addresses, both take effect.
- All read ports are independent; any number of ports may address the same entry.
- Address width rules: the address is unsigned with no wrap logic; every ADDR_W value is a legal entry.
- Mid-operation reset: asserting rst between edges discards any pending write; after release all state equals the post-reset state.

Test Plan:
- Reset with RESET_VAL=32'h0000_0000: assert rst=0 mid-cycle with entries pre-written to 32'hDEAD_BEEF -> all rdata read 0 immediately, without waiting for an edge; rbusy=2'b00.
- Write entry 5 = 32'h1234_5678, then read port0=5 and port1=5 next cycle -> both ports read 32'h1234_5678.
- Bypass, BYPASS=1: wen=1, waddr=7, wdata=32'hA5A5_A5A5, raddr0=7 in the same cycle -> rdata0=32'hA5A5_A5A5 before the edge. With BYPASS=0 the same stimulus -> old value before the edge and 32'hA5A5_A5A5 after it.
- Zero register: write 32'hFFFF_FFFF to address 0 and bset with baddr=0 -> rdata0 for address 0 is 0 every cycle; rbusy0=0.
- Scoreboard:
  - bset with baddr=3, then raddr1=3 -> rbusy1=1 the next cycle.
  - Write to 3 -> rbusy1=0 the next cycle.
  - bset=1 and wen=1 on address 3 in the same cycle -> rbusy1=1 and rdata1=new wdata.
- Clear vs write: clr=1 together with wen=1, waddr=9, wdata=32'h5 -> entry 9 reads RESET_VAL afterwards; all busy bits are 0.
